// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous frame-buffer RAM between
// the VGA display read path (absolute priority during active video) and a
// drawing-engine write port using a req/ack handshake.
// Display read latency is fixed at 3 cycles (Ready_Sig -> Pixel_Valid).
// Optional feature: define VGA_ARB_FRAME_LOCK_EN to restrict writes to the
// vertical sync pulse (tear-free drawing).
module vga_fb_arbiter #(
  parameter int H_RES  = 800,
  parameter int V_RES  = 600,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Ready_Sig,
  input  logic [10:0]       Column_Addr_Sig,
  input  logic [10:0]       Row_Addr_Sig,
  input  logic              VSYNC_Sig,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ack,
  output logic              Wr_Err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic [DATA_W-1:0] Pixel_Data,
  output logic              Pixel_Valid
);

  localparam int unsigned FB_SIZE = H_RES * V_RES;
  // vld_pipe_q[0]: address on the RAM port, [STAGES]: RAM data available
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;

  state_e              state_q, state_d;
  logic [STAGES:0]     vld_pipe_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   pix_q;
  logic                pix_vld_q;
  logic                drop_q;
  logic                ack_q, err_q;

  logic [ADDR_W-1:0]   row_w, col_w, rd_addr;
  logic                grant, issue, wr_in_range;

  // Linear display address Row*H_RES + Column, truncated to ADDR_W.
  assign row_w = ADDR_W'(Row_Addr_Sig);
  assign col_w = ADDR_W'(Column_Addr_Sig);
  generate
    if (H_RES == 800) begin : g_shift_mul
      // 800 = 512 + 256 + 32: shift-add instead of a multiplier
      assign rd_addr = (row_w << 9) + (row_w << 8) + (row_w << 5) + col_w;
    end else begin : g_gen_mul
      assign rd_addr = row_w * ADDR_W'(H_RES) + col_w;
    end
  endgenerate

  // Both paths register onto the RAM port at the same edge, so a write is
  // only granted from a cycle in which the display is not requesting.
`ifdef VGA_ARB_FRAME_LOCK_EN
  assign grant = ~Ready_Sig & ~VSYNC_Sig;
`else
  assign grant = ~Ready_Sig;
  logic unused_vsync;
  assign unused_vsync = VSYNC_Sig;
`endif

  assign issue       = (state_q == IDLE) & Wr_Req & grant;
  assign wr_in_range = 32'(Wr_Addr) < FB_SIZE;

  // Write FSM state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Write FSM next state: IDLE -> WRITE (1 cycle) -> ACK (1 cycle) -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = WRITE;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port: display read has priority; a granted in-range write otherwise
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (Ready_Sig) begin
        mem_addr_q <= rd_addr;
      end else if (issue && wr_in_range) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= Wr_Addr;
        mem_wdata_q <= Wr_Data;
      end
    end
  end

  // Handshake: remember a dropped write, pulse ack/err in the ACK cycle
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      drop_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (issue) drop_q <= ~wr_in_range;
      ack_q <= (state_q == WRITE);
      err_q <= (state_q == WRITE) & drop_q;
    end
  end

  // Read valid pipeline and pixel output register (zero when not valid)
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_pipe_q <= '0;
      pix_q      <= '0;
      pix_vld_q  <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], Ready_Sig};
      pix_vld_q  <= vld_pipe_q[STAGES];
      pix_q      <= vld_pipe_q[STAGES] ? Mem_RData : '0;
    end
  end

  assign Mem_Addr    = mem_addr_q;
  assign Mem_WE      = mem_we_q;
  assign Mem_WData   = mem_wdata_q;
  assign Wr_Ack      = ack_q;
  assign Wr_Err      = err_q;
  assign Pixel_Data  = pix_q;
  assign Pixel_Valid = pix_vld_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: scripted test-plan phase followed by randomized
// display/writer traffic, checked against a transaction-level reference model.
module tb_vga_fb_arbiter;
  localparam int H  = 800;
  localparam int V  = 600;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int N  = 2000;
  localparam int RND_START = 85;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          Ready_Sig = 1'b0;
  logic [10:0]   Column_Addr_Sig = '0;
  logic [10:0]   Row_Addr_Sig = '0;
  logic          VSYNC_Sig = 1'b0;
  logic          Wr_Req = 1'b0;
  logic [AW-1:0] Wr_Addr = '0;
  logic [DW-1:0] Wr_Data = '0;
  logic          Wr_Ack, Wr_Err, Mem_WE, Pixel_Valid;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData, Pixel_Data;
  logic [DW-1:0] Mem_RData;

  vga_fb_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .VSYNC_Sig(VSYNC_Sig), .Wr_Req(Wr_Req), .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data), .Wr_Ack(Wr_Ack), .Wr_Err(Wr_Err),
    .Mem_Addr(Mem_Addr), .Mem_WE(Mem_WE), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Pixel_Data(Pixel_Data), .Pixel_Valid(Pixel_Valid)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port frame RAM, 1-cycle read latency
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] ref_fb [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (Mem_WE) mem[Mem_Addr] <= Mem_WData;
    Mem_RData <= mem[Mem_Addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs indexed by clock edge number
  bit          exp_we  [0:N+4];
  logic [31:0] exp_wa  [0:N+4];
  logic [31:0] exp_wd  [0:N+4];
  bit          exp_ack [0:N+4];
  bit          exp_err [0:N+4];
  bit          exp_rd  [0:N+4];
  logic [31:0] exp_ra  [0:N+4];
  bit          exp_pv  [0:N+4];
  logic [31:0] exp_pd  [0:N+4];

  // Writer / model state
  bit          req_on, granted;
  logic [31:0] req_addr, req_data;
  int          ack_cyc, next_ok;
  bit          rdy_state;
  int          run_left;

  task automatic new_req(input logic [31:0] a, input logic [31:0] d);
    req_on   = 1'b1;
    granted  = 1'b0;
    req_addr = a;
    req_data = d;
  endtask

  function automatic logic [31:0] rnd_addr();
    int sel;
    sel = $urandom_range(9);
    if (sel == 0)      rnd_addr = 32'($urandom_range(524287, H*V));
    else if (sel == 1) rnd_addr = H*V - 1;
    else if (sel == 2) rnd_addr = H*V;
    else               rnd_addr = 32'($urandom_range(H*V-1));
  endfunction

  initial begin
    int a;
    bit gok, inr;
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]    = 8'(i * 7 + 3);
      ref_fb[i] = 8'(i * 7 + 3);
    end
    mem[1605] = 8'hA5; ref_fb[1605] = 8'hA5;
    for (int i = 0; i <= N+4; i++) begin
      exp_we[i] = 0; exp_wa[i] = 0; exp_wd[i] = 0; exp_ack[i] = 0; exp_err[i] = 0;
      exp_rd[i] = 0; exp_ra[i] = 0; exp_pv[i] = 0; exp_pd[i] = 0;
    end
    req_on = 0; granted = 0; req_addr = 0; req_data = 0;
    ack_cyc = -1; next_ok = 0; rdy_state = 0; run_left = 0;

    // Reset state
    #12;
    chk("rst_we", 32'(Mem_WE), 0);
    chk("rst_addr", 32'(Mem_Addr), 0);
    chk("rst_wdata", 32'(Mem_WData), 0);
    chk("rst_ack", 32'(Wr_Ack), 0);
    chk("rst_err", 32'(Wr_Err), 0);
    chk("rst_pv", 32'(Pixel_Valid), 0);
    chk("rst_pd", 32'(Pixel_Data), 0);
    @(posedge CLK); #1;
    RSTn = 1'b1;

    for (int k = 1; k <= N; k++) begin
      @(posedge CLK); #1;
      // ---- check outputs registered at edge k
      chk("we", 32'(Mem_WE), 32'(exp_we[k]));
      if (exp_we[k]) begin
        chk("waddr", 32'(Mem_Addr), exp_wa[k]);
        chk("wdata", 32'(Mem_WData), exp_wd[k]);
      end
      if (exp_rd[k]) chk("raddr", 32'(Mem_Addr), exp_ra[k]);
      chk("ack", 32'(Wr_Ack), 32'(exp_ack[k]));
      chk("err", 32'(Wr_Err), 32'(exp_err[k]));
      chk("pvalid", 32'(Pixel_Valid), 32'(exp_pv[k]));
      chk("pdata", 32'(Pixel_Data), exp_pd[k]);
      // test-plan anchors
      if (k == 12) chk("tp_rd_addr", 32'(Mem_Addr), 1605);
      if (k == 14) chk("tp_pix_a5", 32'(Pixel_Data), 32'h0A5);
      if (k == 16) chk("tp_blank_we", 32'(Mem_WE), 1);
      if (k == 16) chk("tp_blank_addr", 32'(Mem_Addr), 1000);
      if (k == 17) chk("tp_blank_ack", 32'(Wr_Ack), 1);
      if (k == 27) chk("tp_oor_ackerr", 32'({Wr_Ack, Wr_Err}), 3);
      if (k == 81) chk("tp_coll_we", 32'(Mem_WE), 1);

      // ---- writer stimulus for cycle k
      if (granted && k == ack_cyc) begin
        granted = 0; req_on = 0;
        if (k >= RND_START && $urandom_range(1) == 1) new_req(rnd_addr(), 32'($urandom_range(255)));
      end else if (!req_on && k >= RND_START && $urandom_range(2) == 0) begin
        new_req(rnd_addr(), 32'($urandom_range(255)));
      end
      if (k == 15) new_req(1000, 32'h3C);
      if (k == 25) new_req(480000, 32'h55);
      if (k == 30) new_req(2000, 32'h77);
      Wr_Req  = req_on;
      Wr_Addr = req_addr[AW-1:0];
      Wr_Data = req_data[DW-1:0];

      // ---- display stimulus for cycle k
      if (k < RND_START) begin
        Ready_Sig = (k == 11) || (k >= 30 && k <= 79);
        VSYNC_Sig = 1'b0;
        if (k == 11) begin
          Row_Addr_Sig = 11'd2; Column_Addr_Sig = 11'd5;
        end else begin
          Row_Addr_Sig = 11'($urandom_range(V-1)); Column_Addr_Sig = 11'($urandom_range(H-1));
        end
      end else begin
        if (run_left == 0) begin
          rdy_state = !rdy_state;
          run_left  = rdy_state ? $urandom_range(60, 1) : $urandom_range(12, 1);
        end
        run_left--;
        Ready_Sig = rdy_state;
        VSYNC_Sig = ($urandom_range(3) != 0);
        Row_Addr_Sig    = 11'($urandom_range(V-1));
        Column_Addr_Sig = 11'($urandom_range(H-1));
      end

      // ---- reference model: transactions granted/issued from cycle k
`ifdef VGA_ARB_FRAME_LOCK_EN
      gok = !Ready_Sig && !VSYNC_Sig;
`else
      gok = !Ready_Sig;
`endif
      if (req_on && !granted && k >= next_ok && gok) begin
        inr = (req_addr < H*V);
        granted = 1;
        exp_we[k+1] = inr;
        exp_wa[k+1] = req_addr;
        exp_wd[k+1] = req_data;
        exp_ack[k+2] = 1;
        exp_err[k+2] = !inr;
        if (inr) ref_fb[req_addr] = req_data[DW-1:0];
        next_ok = k + 3;
        ack_cyc = k + 2;
      end
      if (Ready_Sig) begin
        a = int'(Row_Addr_Sig) * H + int'(Column_Addr_Sig);
        exp_rd[k+1] = 1;
        exp_ra[k+1] = a;
        exp_pv[k+3] = 1;
        exp_pd[k+3] = 32'(ref_fb[a]);
      end
    end

    // Reset in the middle of a write: no ack, Mem_WE cleared at once
    Wr_Req = 0; Ready_Sig = 0; VSYNC_Sig = 0;
    repeat (5) @(posedge CLK);
    #1;
    Wr_Req = 1; Wr_Addr = 19'd1234; Wr_Data = 8'h12;
    @(posedge CLK); #1;
    chk("mid_we_before_rst", 32'(Mem_WE), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(Mem_WE), 0);
    chk("mid_rst_addr", 32'(Mem_Addr), 0);
    chk("mid_rst_wdata", 32'(Mem_WData), 0);
    chk("mid_rst_pv", 32'(Pixel_Valid), 0);
    Wr_Req = 0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge CLK); #1;
      chk("post_rst_we", 32'(Mem_WE), 0);
      chk("post_rst_ack", 32'(Wr_Ack), 0);
      chk("post_rst_pv", 32'(Pixel_Valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
